// File: rtl/ifu_if.sv
// Instruction-side memory bus: request/accept address phase plus a separate response phase.
interface ifu_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] o_bus_addr;
   logic                  o_bus_cmd;
   logic                  i_bus_ack;
   logic [DATA_WIDTH-1:0] i_bus_rdata;
   logic                  i_bus_rvalid;
   logic                  i_bus_err;

   modport master (
      output o_bus_addr, o_bus_cmd,
      input  i_bus_ack, i_bus_rdata, i_bus_rvalid, i_bus_err
   );

   modport slave (
      input  o_bus_addr, o_bus_cmd,
      output i_bus_ack, i_bus_rdata, i_bus_rvalid, i_bus_err
   );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: runs one single-word read at a time on the instruction bus and
// returns the word, a stall indication and one-cycle alignment/bus error pulses.
module ifu #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_rd_cmd,
   output logic [DATA_WIDTH-1:0] o_instr_dat,
   output logic                  o_busy,
   output logic                  o_err_align,
   output logic                  o_err_bus,
   ifu_if.master                 bus
);

   localparam int unsigned CNT_W = (BUS_TIMEOUT == 0) ? 1 : $clog2(BUS_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic                  err_align_q, err_align_d;
   logic                  err_bus_q, err_bus_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic aligned_c;
   logic timeout_c;
   logic rsp_c;
   logic [CNT_W-1:0] cnt_inc_c;

   assign aligned_c = (i_addr[1:0] == 2'b00);
   assign timeout_c = (BUS_TIMEOUT != 0) && (32'(cnt_q) == 32'(BUS_TIMEOUT));
   assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // Stall in the command cycle itself, before the request is registered.
   assign o_busy = (state_q != IDLE) | (i_rd_cmd & aligned_c);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cmd_q       <= 1'b0;
         instr_q     <= '0;
         err_align_q <= 1'b0;
         err_bus_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cmd_q       <= cmd_d;
         instr_q     <= instr_d;
         err_align_q <= err_align_d;
         err_bus_q   <= err_bus_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cmd_d       = 1'b0;
      instr_d     = instr_q;
      err_align_d = 1'b0;
      err_bus_d   = 1'b0;
      cnt_d       = cnt_q;
      rsp_c       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_rd_cmd) begin
               if (aligned_c) begin
                  addr_d  = i_addr;
                  cmd_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = REQ;
               end else begin
                  err_align_d = 1'b1;
                  instr_d     = '0;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_inc_c;
            if (bus.i_bus_ack && bus.i_bus_rvalid) begin
               rsp_c = 1'b1;
            end else if (timeout_c) begin
               instr_d   = '0;
               err_bus_d = 1'b1;
               state_d   = IDLE;
            end else if (bus.i_bus_ack) begin
               state_d = WAIT;
            end else begin
               cmd_d = 1'b1;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc_c;
            if (bus.i_bus_rvalid) begin
               rsp_c = 1'b1;
            end else if (timeout_c) begin
               instr_d   = '0;
               err_bus_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A real response wins over a timeout landing in the same cycle.
      if (rsp_c) begin
         state_d = IDLE;
         if (bus.i_bus_err) begin
            instr_d   = '0;
            err_bus_d = 1'b1;
         end else begin
            instr_d = bus.i_bus_rdata;
         end
      end
   end

   assign o_instr_dat    = instr_q;
   assign o_err_align    = err_align_q;
   assign o_err_bus      = err_bus_q;
   assign bus.o_bus_addr = addr_q;
   assign bus.o_bus_cmd  = cmd_q;

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit; sits directly upstream of the fetch pipeline stage.
- Accepts single-word read commands from fetch and runs them on the instruction-side memory bus (request/accept address phase, separate response phase).
- Returns the instruction word, a busy/stall indication and alignment and bus error flags.
- One transaction in flight at a time; no prefetch, no cache.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches CPU address width).
- DATA_WIDTH, 32, instruction word width.
- BUS_TIMEOUT, 255, maximum cycles spent waiting for a response before a bus error is forced; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- i_addr  in  ADDR_WIDTH  fetch address, sampled when i_rd_cmd=1.
- i_rd_cmd  in  1  single-cycle read command from fetch.
- o_instr_dat  out  DATA_WIDTH  last returned instruction; stable while idle.
- o_busy  out  1  transaction pending; fetch uses it as stall.
- o_err_align  out  1  one-cycle pulse: command address not word aligned.
- o_err_bus  out  1  one-cycle pulse: bus error response or timeout.
- o_bus_addr  out  ADDR_WIDTH  bus request address.
- o_bus_cmd  out  1  bus read request valid.
- i_bus_ack  in  1  bus accepted request this cycle.
- i_bus_rdata  in  DATA_WIDTH  bus read data.
- i_bus_rvalid  in  1  response valid this cycle.
- i_bus_err  in  1  response is an error; qualified by i_bus_rvalid.

Behaviour:
- Reset (nrst=0 at posedge): state IDLE, o_instr_dat=0 (NOP), o_bus_addr=0, o_bus_cmd=0, o_err_align=0, o_err_bus=0, timeout counter=0.
- Reset mid-transaction: any outstanding request is abandoned. A response arriving after reset is ignored because i_bus_rvalid is don't-care in IDLE.
- States:
  - IDLE: no transaction pending.
  - REQ: o_bus_cmd=1, waiting for i_bus_ack.
  - WAIT: waiting for i_bus_rvalid.
- o_busy = (state != IDLE) | (i_rd_cmd & state==IDLE & addr aligned).
  - Combinational from i_rd_cmd, so the fetch stage stalls in the command cycle itself.
- IDLE with i_rd_cmd=1 and i_addr[1:0]==0:
  - Latch o_bus_addr=i_addr; go to REQ.
- IDLE with i_rd_cmd=1 and i_addr[1:0]!=0:
  - No bus request; stay IDLE.
  - Next cycle o_err_align=1 for one cycle and o_instr_dat=0.
- REQ: o_bus_cmd=1 and o_bus_addr held stable until i_bus_ack=1, then go to WAIT.
  - If i_bus_ack=1 and i_bus_rvalid=1 in the same REQ cycle, treat it as a complete transaction and go straight to IDLE.
- WAIT, i_bus_rvalid=1, i_bus_err=0: o_instr_dat<=i_bus_rdata; go to IDLE.
- WAIT, i_bus_rvalid=1, i_bus_err=1: o_instr_dat<=0; o_err_bus pulses next cycle; go to IDLE.
- Timeout counter:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT.
  - When BUS_TIMEOUT!=0 and the count reaches BUS_TIMEOUT, behave as an error response: o_instr_dat<=0, o_err_bus pulse, go to IDLE.
  - Counter width is clog2(BUS_TIMEOUT+1); it saturates and never wraps.
- i_rd_cmd while state!=IDLE is ignored. This is a protocol violation; fetch never issues it because o_busy is high.
- i_bus_rvalid in IDLE or REQ without ack is ignored.
- Error flags are registered and mutually exclusive; each is high for exactly one cycle per event.
- Latency, zero-wait bus (ack in REQ cycle, rvalid the following cycle):
  - Command in cycle N, REQ in N+1, WAIT in N+2 with rvalid.
  - o_instr_dat valid and o_busy=0 in N+3.
- o_instr_dat changes only at transaction completion, error or reset.

Test Plan:
- Reset, then i_rd_cmd with i_addr=0x0000_0100, bus acks in REQ and returns 0x2408_0005 one cycle later -> o_bus_cmd=1 for 1 cycle with o_bus_addr=0x100; o_busy=1 cycles N..N+2; o_instr_dat=0x2408_0005 and o_busy=0 at N+3.
- Bus withholds i_bus_ack for 3 cycles, then rvalid after 2 more -> o_bus_cmd/o_bus_addr stable all 4 REQ cycles; o_busy held; no extra request issued.
- i_rd_cmd with i_addr=0x0000_0102 -> no o_bus_cmd; o_err_align=1 one cycle at N+1; o_instr_dat=0; o_busy=0 at N+1.
- Response with i_bus_err=1 -> o_err_bus pulse one cycle; o_instr_dat=0; next aligned command (addr 0x104, data 0x0000_000C) completes normally.
- BUS_TIMEOUT=4, bus acks but never returns rvalid -> o_err_bus pulse after 4 counted cycles; state IDLE; a late rvalid with 0xDEAD_BEEF is ignored and o_instr_dat stays 0.
- nrst=0 asserted while in WAIT, released, then rvalid with 0x1234_5678 -> o_busy=0, o_instr_dat=0, no error pulse; a subsequent fetch of addr 0x0 completes normally.
